// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// default register-index width, mux select encodings and the tag-slot record.
package forward_ctrl_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF     = 2'd0,
      FWD_EXMEM  = 2'd1,
      FWD_MEMWB  = 2'd2,
      FWD_RETIRE = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic             valid;
      logic             reg_write;
      logic             mem_read;
      logic [REG_W-1:0] dest;
   } tag_slot_t;

endpackage

// File: rtl/forward_ctrl_fwd_match.sv
// Combinational producer search for one source operand across the EX, MEM and
// WB tag slots; the youngest slot that writes the source register wins.
module fwd_match #(
   parameter int unsigned REG_W = forward_ctrl_pkg::REG_W
) (
   input  logic [REG_W-1:0] src_i,
   input  logic [REG_W+2:0] ex_slot_i,
   input  logic [REG_W+2:0] mem_slot_i,
   input  logic [REG_W+2:0] wb_slot_i,
   output logic [1:0]       sel_o
);
   import forward_ctrl_pkg::*;

   // Slot layout is {valid, reg_write, mem_read, dest}; mem_read only matters for stall.
   function automatic logic produces(input logic [REG_W+2:0] slot,
                                     input logic [REG_W-1:0] r);
      return slot[REG_W+2] && slot[REG_W+1] &&
             (slot[REG_W-1:0] == r) && (r != '0);
   endfunction

   logic unused_mem_read;
   assign unused_mem_read = ex_slot_i[REG_W] ^ mem_slot_i[REG_W] ^ wb_slot_i[REG_W];

   always_comb begin
      sel_o = FWD_RF;
      if (produces(ex_slot_i, src_i)) begin
         sel_o = FWD_EXMEM;
      end else if (produces(mem_slot_i, src_i)) begin
         sel_o = FWD_MEMWB;
      end else if (produces(wb_slot_i, src_i)) begin
         sel_o = FWD_RETIRE;
      end
   end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller: tracks EX/MEM/WB destination tags
// and registers operand-mux selects for the instruction entering EX.
module forward_ctrl #(
   parameter int unsigned REG_W = forward_ctrl_pkg::REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel
);
   import forward_ctrl_pkg::*;

   typedef struct packed {
      logic             valid;
      logic             reg_write;
      logic             mem_read;
      logic [REG_W-1:0] dest;
   } slot_t;

   slot_t      ex_q, mem_q, wb_q;
   slot_t      ex_d;
   logic [1:0] sel_a_q, sel_a_d;
   logic [1:0] sel_b_q, sel_b_d;
   logic [1:0] match_a, match_b;
   logic       load_hit;
   logic       ex_load;

   // Load-use hazard is judged on EX alone; flush is deliberately left out so
   // the branch unit can consume stall without forming a combinational loop.
   assign load_hit = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) &&
                     ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));
   assign stall    = id_valid && load_hit;
   assign ex_load  = id_valid && !stall && !flush;

   fwd_match #(.REG_W(REG_W)) u_match_a (
      .src_i      (id_rs),
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .wb_slot_i  (wb_q),
      .sel_o      (match_a)
   );

   fwd_match #(.REG_W(REG_W)) u_match_b (
      .src_i      (id_rt),
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .wb_slot_i  (wb_q),
      .sel_o      (match_b)
   );

   always_comb begin
      ex_d    = '0;
      sel_a_d = FWD_RF;
      sel_b_d = FWD_RF;
      if (ex_load) begin
         ex_d.valid     = 1'b1;
         ex_d.reg_write = id_reg_write;
         ex_d.mem_read  = id_mem_read;
         ex_d.dest      = id_dest;
         sel_a_d        = match_a;
         sel_b_d        = match_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         sel_a_q <= FWD_RF;
         sel_b_q <= FWD_RF;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   assign fwd_a_sel = sel_a_q;
   assign fwd_b_sel = sel_b_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed hazard scenarios with literal expectations,
// then randomized traffic checked each cycle against an instruction-history model.
module tb_forward_ctrl;
   import forward_ctrl_pkg::*;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] dest;
      logic             rw;
      logic             mr;
   } instr_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             id_valid = 1'b0;
   logic [REG_W-1:0] id_rs = '0;
   logic [REG_W-1:0] id_rt = '0;
   logic [REG_W-1:0] id_dest = '0;
   logic             id_reg_write = 1'b0;
   logic             id_mem_read = 1'b0;
   logic             flush = 1'b0;
   logic             stall;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;

   int n_cmp  = 0;
   int n_fail = 0;

   forward_ctrl #(.REG_W(REG_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_dest      (id_dest),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .stall        (stall),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the last three instructions that entered EX, youngest first.
   tag_slot_t   hist[$];
   logic [3:0]  exp_q[$];

   function automatic logic produces(input tag_slot_t e, input logic [REG_W-1:0] r);
      return e.valid && e.reg_write && (e.dest == r) && (r != 0);
   endfunction

   function automatic logic [1:0] youngest(input logic [REG_W-1:0] r);
      for (int i = 0; i < 3; i++)
         if (produces(hist[i], r)) return 2'(i + 1);
      return 2'd0;
   endfunction

   function automatic logic model_stall();
      return id_valid && hist[0].valid && hist[0].mem_read && (hist[0].dest != 0) &&
             (hist[0].dest == id_rs || hist[0].dest == id_rt);
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) hist.push_back('0);
   end

   always @(posedge clk) begin
      tag_slot_t ent;
      logic      go;
      logic [1:0] sa, sb;
      ent = '0;
      sa  = 2'd0;
      sb  = 2'd0;
      if (rst) begin
         for (int i = 0; i < 3; i++) hist[i] = '0;
      end else begin
         go = id_valid && !flush && !model_stall();
         if (go) begin
            sa = youngest(id_rs);
            sb = youngest(id_rt);
            ent.valid     = 1'b1;
            ent.reg_write = id_reg_write;
            ent.mem_read  = id_mem_read;
            ent.dest      = id_dest;
         end
         hist.push_front(ent);
         void'(hist.pop_back());
      end
      exp_q.push_back({sa, sb});
   end

   // Scoreboard compare, mid-cycle
   always @(negedge clk) begin
      logic [3:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_sel_a", fwd_a_sel, e[3:2]);
         chk("sb_sel_b", fwd_b_sel, e[1:0]);
         chk("sb_stall", {1'b0, stall}, {1'b0, model_stall()});
      end
   end

   // Driver: present one ID slot for a cycle; returns stall seen mid-cycle.
   task automatic drive(input instr_t in, input logic fl, output logic st);
      id_valid     = in.v;
      id_rs        = in.rs;
      id_rt        = in.rt;
      id_dest      = in.dest;
      id_reg_write = in.rw;
      id_mem_read  = in.mr;
      flush        = fl;
      @(negedge clk);
      st = stall;
      @(posedge clk);
      #2;
   endtask

   function automatic instr_t alu(input int d, input int s, input int t);
      instr_t r;
      r = '{v: 1'b1, rs: REG_W'(s), rt: REG_W'(t), dest: REG_W'(d), rw: 1'b1, mr: 1'b0};
      return r;
   endfunction

   function automatic instr_t lw(input int d, input int s);
      instr_t r;
      r = alu(d, s, 0);
      r.mr = 1'b1;
      return r;
   endfunction

   task automatic nops(input int n);
      logic st;
      for (int i = 0; i < n; i++) drive('0, 1'b0, st);
   endtask

   initial begin
      logic   st;
      instr_t cur;
      logic   fl;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_sel_a", fwd_a_sel, 2'd0);
      chk("reset_sel_b", fwd_b_sel, 2'd0);
      chk("reset_stall", {1'b0, stall}, 2'd0);
      rst = 1'b0;
      nops(1);

      // back-to-back ALU dependency
      drive(alu(3, 1, 2), 1'b0, st);
      drive(alu(4, 3, 1), 1'b0, st);
      chk("b2b_sel_a", fwd_a_sel, 2'd1);
      chk("b2b_sel_b", fwd_b_sel, 2'd0);
      nops(3);

      // distance 2, 3, 4
      for (int gap = 1; gap <= 3; gap++) begin
         drive(alu(5, 1, 2), 1'b0, st);
         nops(gap);
         drive(alu(6, 1, 5), 1'b0, st);
         chk("dist_sel_b", fwd_b_sel, (gap == 1) ? 2'd2 : (gap == 2) ? 2'd3 : 2'd0);
         nops(3);
      end

      // load-use
      drive(lw(7, 1), 1'b0, st);
      drive(alu(8, 7, 7), 1'b0, st);
      chk("lu_stall", {1'b0, st}, 2'd1);
      chk("lu_bubble_a", fwd_a_sel, 2'd0);
      chk("lu_bubble_b", fwd_b_sel, 2'd0);
      drive(alu(8, 7, 7), 1'b0, st);
      chk("lu_retry_stall", {1'b0, st}, 2'd0);
      chk("lu_retry_a", fwd_a_sel, 2'd2);
      chk("lu_retry_b", fwd_b_sel, 2'd2);
      nops(3);

      // r0 never forwards nor stalls
      drive(alu(0, 1, 2), 1'b0, st);
      drive(alu(9, 0, 0), 1'b0, st);
      chk("r0_alu_a", fwd_a_sel, 2'd0);
      chk("r0_alu_b", fwd_b_sel, 2'd0);
      drive(lw(0, 1), 1'b0, st);
      drive(alu(9, 0, 0), 1'b0, st);
      chk("r0_lw_stall", {1'b0, st}, 2'd0);
      chk("r0_lw_a", fwd_a_sel, 2'd0);
      nops(3);

      // flush while a load-use hazard is pending
      drive(lw(9, 1), 1'b0, st);
      drive(alu(10, 9, 2), 1'b1, st);
      chk("fl_stall_raw", {1'b0, st}, 2'd1);
      chk("fl_bubble_a", fwd_a_sel, 2'd0);
      chk("fl_bubble_b", fwd_b_sel, 2'd0);
      drive(alu(10, 9, 2), 1'b0, st);
      chk("fl_no_second_stall", {1'b0, st}, 2'd0);
      chk("fl_after_a", fwd_a_sel, 2'd2);
      nops(3);

      // reset in the middle of a load-use pair
      drive(lw(11, 1), 1'b0, st);
      rst = 1'b1;
      drive(alu(12, 11, 11), 1'b0, st);
      rst = 1'b0;
      chk("rst_mid_a", fwd_a_sel, 2'd0);
      chk("rst_mid_b", fwd_b_sel, 2'd0);
      chk("rst_mid_stall", {1'b0, stall}, 2'd0);
      drive(alu(12, 11, 11), 1'b0, st);
      chk("rst_after_a", fwd_a_sel, 2'd0);
      nops(3);

      // youngest producer wins; independent A/B matches
      drive(alu(2, 1, 1), 1'b0, st);
      drive(alu(2, 3, 3), 1'b0, st);
      drive(alu(13, 2, 2), 1'b0, st);
      chk("young_a", fwd_a_sel, 2'd1);
      chk("young_b", fwd_b_sel, 2'd1);
      nops(3);
      drive(alu(14, 1, 1), 1'b0, st);
      drive(alu(15, 1, 1), 1'b0, st);
      drive(alu(16, 14, 15), 1'b0, st);
      chk("indep_a", fwd_a_sel, 2'd2);
      chk("indep_b", fwd_b_sel, 2'd1);

      // randomized traffic; a stalled instruction is re-presented next cycle
      cur = '0;
      st  = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!st) begin
            cur.v    = ($urandom_range(0, 9) < 8);
            cur.rs   = REG_W'($urandom_range(0, 7));
            cur.rt   = REG_W'($urandom_range(0, 7));
            cur.dest = REG_W'($urandom_range(0, 7));
            cur.rw   = ($urandom_range(0, 3) != 0);
            cur.mr   = ($urandom_range(0, 9) < 3);
         end
         fl  = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 49) == 0);
         drive(cur, fl, st);
         if (fl || rst) st = 1'b0;
      end
      rst = 1'b0;
      nops(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
